// File: rtl/ysyx_23060236_uart_lite.sv
// AXI4-lite UART transmitter: TX FIFO, programmable baud divisor, 8N1 txd.
// TXDATA at BASE_ADDR, STATUS at +4, DIVISOR at +8.
module ysyx_23060236_uart_lite #(
    parameter logic [31:0] BASE_ADDR  = 32'ha00003f8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd868,
    parameter bit          SIM_PRINT  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        txd
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    logic [31:0] r_awaddr;
    logic        r_aw_got;
    logic [15:0] r_wdata;
    logic [1:0]  r_wstrb;
    logic        r_w_got;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [15:0] r_div;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    state_t      r_state;
    logic [7:0]  r_shift;
    logic [15:0] r_bdiv;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic        r_txd;

    logic        w_wr_exec;
    logic        w_is_tx;
    logic        w_is_st;
    logic        w_is_div;
    logic [1:0]  w_wr_resp;
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic [AW:0] w_level;
    logic [7:0]  w_level8;
    logic        w_busy;
    logic [7:0]  w_fifo_out;
    logic [15:0] w_div_eff;
    logic        w_bit_end;
    logic [31:0] w_status;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic        w_unused;

    assign awready = ~r_aw_got;
    assign wready  = ~r_w_got;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = ~r_rvalid;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign txd     = r_txd;

    assign w_unused = &{1'b0, wdata[31:16], wstrb[3:2]};

    assign w_wr_exec = r_aw_got & r_w_got & ~r_bvalid;
    assign w_is_tx   = r_awaddr == BASE_ADDR;
    assign w_is_st   = r_awaddr == BASE_ADDR + 32'd4;
    assign w_is_div  = r_awaddr == BASE_ADDR + 32'd8;

    assign w_empty  = r_wptr == r_rptr;
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_level  = r_wptr - r_rptr;
    assign w_level8 = 8'(w_level);
    assign w_busy   = r_state != S_IDLE;
    assign w_status = {16'b0, w_level8, 5'b0, w_busy, w_empty, w_full};

    assign w_fifo_out = r_mem[r_rptr[AW-1:0]];
    assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_bit_end  = r_cnt == r_bdiv - 16'd1;

    // full is sampled before the edge, so a same-cycle pop never frees a slot
    assign w_push = w_wr_exec & w_is_tx & r_wstrb[0] & ~w_full;
    assign w_pop  = ~w_empty & ((r_state == S_IDLE) |
                    ((r_state == S_STOP) & w_bit_end));

    always_comb begin
        w_wr_resp = 2'b11;
        if (w_is_tx)
            w_wr_resp = (r_wstrb[0] && w_full) ? 2'b10 : 2'b00;
        else if (w_is_st || w_is_div)
            w_wr_resp = 2'b00;
    end

    always_comb begin
        w_rd_data = 32'd0;
        w_rd_resp = 2'b00;
        if (araddr == BASE_ADDR + 32'd4)
            w_rd_data = w_status;
        else if (araddr == BASE_ADDR + 32'd8)
            w_rd_data = {16'b0, r_div};
        else if (araddr != BASE_ADDR)
            w_rd_resp = 2'b11;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aw_got <= 1'b0;
            r_awaddr <= 32'd0;
            r_w_got  <= 1'b0;
            r_wdata  <= 16'd0;
            r_wstrb  <= 2'b0;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b0;
            r_div    <= DIV_RESET;
        end else begin
            if (awvalid && !r_aw_got) begin
                r_aw_got <= 1'b1;
                r_awaddr <= awaddr;
            end
            if (wvalid && !r_w_got) begin
                r_w_got <= 1'b1;
                r_wdata <= wdata[15:0];
                r_wstrb <= wstrb[1:0];
            end
            if (w_wr_exec) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_resp;
                if (w_is_div && r_wstrb[0]) r_div[7:0]  <= r_wdata[7:0];
                if (w_is_div && r_wstrb[1]) r_div[15:8] <= r_wdata[15:8];
            end
            if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'b0;
        end else if (arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= r_wdata[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_bdiv  <= 16'd1;
        end else begin
            case (r_state)
                S_IDLE: if (!w_empty) begin
                    r_state <= S_LOAD;
                    r_shift <= w_fifo_out;
                    r_bdiv  <= w_div_eff;
                end
                S_LOAD: begin
                    r_state <= S_START;
                    r_txd   <= 1'b0;
                    r_cnt   <= 16'd0;
                end
                S_START: if (w_bit_end) begin
                    r_state <= S_DATA;
                    r_txd   <= r_shift[0];
                    r_bit   <= 3'd0;
                    r_cnt   <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                S_DATA: if (w_bit_end) begin
                    r_cnt <= 16'd0;
                    if (r_bit == 3'd7) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_bit   <= r_bit + 3'd1;
                        r_txd   <= r_shift[1];
                        r_shift <= r_shift >> 1;
                    end
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                S_STOP: if (w_bit_end) begin
                    r_cnt <= 16'd0;
                    if (!w_empty) begin
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                        r_shift <= w_fifo_out;
                        r_bdiv  <= w_div_eff;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        if (SIM_PRINT) begin : g_echo
`ifndef SYNTHESIS
            always @(posedge clock) begin
                if (!reset && w_push) $write("%c", r_wdata[7:0]);
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_23060236_uart_lite.sv
// Directed bench for ysyx_23060236_uart_lite: register access, AXI handshakes,
// FIFO overflow, 8N1 frame shape and reset abort.
module tb_ysyx_23060236_uart_lite;
    localparam logic [31:0] TXA = 32'ha00003f8;
    localparam logic [31:0] STA = 32'ha00003fc;
    localparam logic [31:0] DVA = 32'ha0000400;
    localparam logic [31:0] BAD = 32'ha0000404;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, txd;
    logic [1:0]  bresp, rresp;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_23060236_uart_lite dut (
        .clock(clk), .reset(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .txd(txd)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
        logic ad, wd, ah, wh;
        int n;
        @(posedge clk); #1;
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        ad = 1'b0; wd = 1'b0; n = 0;
        while (!(ad && wd) && n < 20) begin
            @(negedge clk);
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(posedge clk); #1;
            if (ah) begin awvalid = 1'b0; ad = 1'b1; end
            if (wh) begin wvalid = 1'b0; wd = 1'b1; end
            n++;
        end
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bvalid) break;
            n++;
        end
        chk("bvalid_seen", bvalid, 1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r);
        logic h;
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            h = arvalid && arready;
            @(posedge clk); #1;
            if (h) break;
        end
        arvalid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (rvalid) break;
            n++;
        end
        chk("rvalid_seen", rvalid, 1);
        d = rdata;
        r = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  resps [18];
        logic [9:0]  pat;
        logic        low;
        int          n;

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_txd", txd, 1);
        axi_rd(STA, d, r);
        chk("rst_status", d, 32'h2);
        chk("rst_status_resp", r, 0);
        axi_rd(DVA, d, r);
        chk("rst_divisor", d, 32'h364);
        axi_rd(TXA, d, r);
        chk("txdata_rd", d, 0);
        chk("txdata_rd_resp", r, 0);

        // AW leads W by 5 cycles, then B is stalled for 3 cycles
        @(posedge clk); #1;
        awaddr = TXA; awvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("aw_dropped", awready, 0);
            @(posedge clk);
        end
        #1;
        wdata = 32'h42; wstrb = 4'h1; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (bvalid) break;
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("b_held", bvalid, 1);
            chk("b_held_wready", wready, 0);
            chk("b_held_resp", bresp, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        chk("aw_back", awready, 1);
        chk("w_back", wready, 1);
        chk("b_cleared", bvalid, 0);
        axi_rd(STA, d, r);
        chk("one_push_status", d, 32'h6);

        axi_wr(BAD, 32'hffff, 4'hf, r);
        chk("decerr_wr", r, 2'b11);
        axi_rd(BAD, d, r);
        chk("decerr_rd_data", d, 0);
        chk("decerr_rd_resp", r, 2'b11);
        axi_rd(STA, d, r);
        chk("decerr_status", d, 32'h6);
        axi_rd(DVA, d, r);
        chk("decerr_div", d, 32'h364);
        axi_wr(TXA, 32'h43, 4'he, r);
        chk("nostrb_resp", r, 0);
        axi_wr(STA, 32'hff, 4'hf, r);
        chk("status_wr_resp", r, 0);
        axi_rd(STA, d, r);
        chk("nostrb_status", d, 32'h6);
        axi_wr(DVA, 32'habcd, 4'h2, r);
        axi_rd(DVA, d, r);
        chk("div_merge", d, 32'hab64);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_txd", txd, 1);
        @(posedge clk); #1 rst = 1'b0;
        axi_rd(STA, d, r);
        chk("rst2_status", d, 32'h2);
        axi_rd(DVA, d, r);
        chk("rst2_div", d, 32'h364);

        axi_wr(DVA, 32'h4, 4'h3, r);
        chk("div4_resp", r, 0);
        axi_wr(TXA, 32'h41, 4'h1, r);
        chk("tx41_resp", r, 0);
        n = 0;
        while (n < 20) begin
            n++;
            @(negedge clk);
            if (txd == 1'b0) break;
        end
        chk("start_latency", n, 2);
        pat = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("frame41_%0d", k), txd, pat[k/4]);
        end
        repeat (5) @(posedge clk);
        axi_rd(STA, d, r);
        chk("after_frame_status", d, 32'h2);
        axi_wr(TXA, 32'h55, 4'h1, r);
        axi_rd(STA, d, r);
        chk("busy_status", d, 32'h6);
        repeat (60) @(posedge clk);
        axi_rd(STA, d, r);
        chk("idle_status", d, 32'h2);

        axi_wr(DVA, 32'd100, 4'h3, r);
        for (int i = 0; i < 18; i++) begin
            axi_wr(TXA, 32'h61 + i, 4'h1, r);
            resps[i] = r;
        end
        chk("push1_resp", resps[0], 0);
        chk("push17_resp", resps[16], 0);
        chk("push18_resp", resps[17], 2'b10);
        axi_rd(STA, d, r);
        chk("full_status", d, 32'h1005);

        n = 0;
        while (txd != 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (txd != 1'b0 && n < 400) begin @(negedge clk); n++; end
        chk("mid_data_low", txd, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_txd", txd, 1);
        @(posedge clk); #1 rst = 1'b0;
        low = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) low = 1'b1;
        end
        chk("no_resume", low, 0);
        axi_rd(STA, d, r);
        chk("abort_status", d, 32'h2);
        axi_rd(DVA, d, r);
        chk("abort_div", d, 32'h364);

        $display("");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
